// File: rtl/ddr_cmd_seq_pkg.sv
// Shared definitions for the DDR command sequencer: command and tracker
// verdict encodings, FSM states and default timing values.
package ddr_cmd_seq_pkg;

  // DDR command bus encodings
  typedef enum logic [2:0] {
    CMD_NOP    = 3'b000,
    CMD_PRE    = 3'b001,
    CMD_ACT    = 3'b010,
    CMD_RD     = 3'b011,
    CMD_WR     = 3'b100,
    CMD_PREALL = 3'b101,
    CMD_REF    = 3'b110
  } cmd_e;

  // Open-bank tracker verdicts (one-hot)
  localparam logic [2:0] OPS_HIT      = 3'b001;
  localparam logic [2:0] OPS_MISS     = 3'b010;
  localparam logic [2:0] OPS_CONFLICT = 3'b100;

  // Sequencer states
  typedef enum logic [3:0] {
    S_IDLE,
    S_CLASSIFY,
    S_PRE,
    S_WAIT_RP,
    S_ACT,
    S_WAIT_RCD,
    S_RW,
    S_REF_PREALL,
    S_REF_WAIT_RP,
    S_REF,
    S_REF_WAIT_RFC
  } state_e;

  // Default timing, in clock cycles
  localparam int unsigned DEF_TRP  = 3;
  localparam int unsigned DEF_TRCD = 3;
  localparam int unsigned DEF_TRFC = 51;

  // A10 set selects all banks for PRECHARGE-ALL
  localparam logic [13:0] PREALL_ADDR = 14'h0400;

  // Counter preload for a spacing of t cycles: the command cycle itself and
  // the cycle of the dependent command account for two of them.
  function automatic logic [7:0] waitLoad(input int unsigned t);
    if (t >= 2) begin
      return 8'(t - 2);
    end
    return 8'd0;
  endfunction

endpackage

// File: rtl/ddr_wait_ctr.sv
// Loadable 8-bit down-counter with a zero flag, used to time the WAIT states.
module ddr_wait_ctr
  import ddr_cmd_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_loadVal,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [7:0] r_count;

  // Load has priority over decrement; the count holds at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_dec && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/ddr_cmd_seq.sv
// DDR command sequencer: turns accepted requests into PRE/ACT/RD/WR sequences
// according to the open-bank tracker verdict, and runs PREALL/REF refreshes.
module ddr_cmd_seq
  import ddr_cmd_seq_pkg::*;
#(
  parameter int unsigned TRP  = DEF_TRP,
  parameter int unsigned TRCD = DEF_TRCD,
  parameter int unsigned TRFC = DEF_TRFC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_reqValid,
  output logic        o_reqReady,
  input  logic        i_reqRank,
  input  logic [2:0]  i_reqBank,
  input  logic [13:0] i_reqRow,
  input  logic [9:0]  i_reqCol,
  input  logic        i_reqWrite,
  output logic        o_doOp,
  input  logic [2:0]  i_numOps,
  input  logic        i_refReq,
  input  logic        i_refRankIn,
  output logic        o_refAck,
  output logic        o_doReset,
  output logic        o_refRank,
  output logic [2:0]  o_cmd,
  output logic        o_cmdRank,
  output logic [2:0]  o_cmdBank,
  output logic [13:0] o_cmdAddr
);

  localparam logic [7:0] LD_TRP  = waitLoad(TRP);
  localparam logic [7:0] LD_TRCD = waitLoad(TRCD);
  localparam logic [7:0] LD_TRFC = waitLoad(TRFC);

  state_e      r_state;
  state_e      w_nextState;

  logic        r_rank;
  logic [2:0]  r_bank;
  logic [13:0] r_row;
  logic [9:0]  r_col;
  logic        r_write;
  logic        r_refRank;
  logic        r_refAck;

  cmd_e        r_cmd;
  logic        r_cmdRank;
  logic [2:0]  r_cmdBank;
  logic [13:0] r_cmdAddr;

  cmd_e        w_nextCmd;
  logic        w_nextRank;
  logic [2:0]  w_nextBank;
  logic [13:0] w_nextAddr;
  logic        w_nextRefAck;

  logic        w_reqReady;
  logic        w_doOp;
  logic        w_doReset;
  logic        w_load;
  logic [7:0]  w_loadVal;
  logic        w_dec;
  logic        w_zero;

  ddr_wait_ctr u_waitCtr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_load),
    .i_loadVal (w_loadVal),
    .i_dec     (w_dec),
    .o_zero    (w_zero)
  );

  // Requests are only taken in IDLE when no refresh is pending. In the refAck
  // cycle refReq may still be high, so it is not allowed to restart a refresh.
  assign w_reqReady = (r_state == S_IDLE) && !i_refReq && !i_rst;
  assign w_doOp     = i_reqValid && w_reqReady;
  assign w_doReset  = (r_state == S_IDLE) && i_refReq && !r_refAck && !i_rst;

  assign o_reqReady = w_reqReady;
  assign o_doOp     = w_doOp;
  assign o_doReset  = w_doReset;
  assign o_refRank  = w_doReset ? i_refRankIn : r_refRank;
  assign o_refAck   = r_refAck;
  assign o_cmd      = r_cmd;
  assign o_cmdRank  = r_cmdRank;
  assign o_cmdBank  = r_cmdBank;
  assign o_cmdAddr  = r_cmdAddr;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state, counter control, and the command for the state being entered
  always_comb begin
    w_nextState  = r_state;
    w_load       = 1'b0;
    w_loadVal    = 8'd0;
    w_dec        = 1'b0;
    w_nextRefAck = 1'b0;
    w_nextCmd    = CMD_NOP;
    w_nextRank   = 1'b0;
    w_nextBank   = 3'd0;
    w_nextAddr   = 14'd0;

    case (r_state)
      S_IDLE: begin
        if (w_doReset) begin
          w_nextState = S_REF_PREALL;
        end else if (w_doOp) begin
          w_nextState = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        case (i_numOps)
          OPS_HIT:  w_nextState = S_RW;
          OPS_MISS: w_nextState = S_ACT;
          default:  w_nextState = S_PRE;
        endcase
      end
      S_PRE: begin
        if (TRP == 1) begin
          w_nextState = S_ACT;
        end else begin
          w_load      = 1'b1;
          w_loadVal   = LD_TRP;
          w_nextState = S_WAIT_RP;
        end
      end
      S_WAIT_RP: begin
        w_dec = 1'b1;
        if (w_zero) begin
          w_nextState = S_ACT;
        end
      end
      S_ACT: begin
        if (TRCD == 1) begin
          w_nextState = S_RW;
        end else begin
          w_load      = 1'b1;
          w_loadVal   = LD_TRCD;
          w_nextState = S_WAIT_RCD;
        end
      end
      S_WAIT_RCD: begin
        w_dec = 1'b1;
        if (w_zero) begin
          w_nextState = S_RW;
        end
      end
      S_RW: begin
        w_nextState = S_IDLE;
      end
      S_REF_PREALL: begin
        if (TRP == 1) begin
          w_nextState = S_REF;
        end else begin
          w_load      = 1'b1;
          w_loadVal   = LD_TRP;
          w_nextState = S_REF_WAIT_RP;
        end
      end
      S_REF_WAIT_RP: begin
        w_dec = 1'b1;
        if (w_zero) begin
          w_nextState = S_REF;
        end
      end
      S_REF: begin
        if (TRFC == 1) begin
          w_nextState  = S_IDLE;
          w_nextRefAck = 1'b1;
        end else begin
          w_load      = 1'b1;
          w_loadVal   = LD_TRFC;
          w_nextState = S_REF_WAIT_RFC;
        end
      end
      S_REF_WAIT_RFC: begin
        w_dec = 1'b1;
        if (w_zero) begin
          w_nextState  = S_IDLE;
          w_nextRefAck = 1'b1;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase

    // Command states never loop on themselves, so each command lasts one cycle
    case (w_nextState)
      S_PRE: begin
        w_nextCmd  = CMD_PRE;
        w_nextRank = r_rank;
        w_nextBank = r_bank;
      end
      S_ACT: begin
        w_nextCmd  = CMD_ACT;
        w_nextRank = r_rank;
        w_nextBank = r_bank;
        w_nextAddr = r_row;
      end
      S_RW: begin
        w_nextCmd  = r_write ? CMD_WR : CMD_RD;
        w_nextRank = r_rank;
        w_nextBank = r_bank;
        w_nextAddr = {4'b0000, r_col};
      end
      S_REF_PREALL: begin
        w_nextCmd  = CMD_PREALL;
        w_nextRank = i_refRankIn;
        w_nextAddr = PREALL_ADDR;
      end
      S_REF: begin
        w_nextCmd  = CMD_REF;
        w_nextRank = r_refRank;
      end
      default: begin
        w_nextCmd = CMD_NOP;
      end
    endcase
  end

  // Registered command bus and refresh acknowledge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cmd     <= CMD_NOP;
      r_cmdRank <= 1'b0;
      r_cmdBank <= 3'd0;
      r_cmdAddr <= 14'd0;
      r_refAck  <= 1'b0;
    end else begin
      r_cmd     <= w_nextCmd;
      r_cmdRank <= w_nextRank;
      r_cmdBank <= w_nextBank;
      r_cmdAddr <= w_nextAddr;
      r_refAck  <= w_nextRefAck;
    end
  end

  // Capture request fields on accept and the refresh rank on refresh start
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rank    <= 1'b0;
      r_bank    <= 3'd0;
      r_row     <= 14'd0;
      r_col     <= 10'd0;
      r_write   <= 1'b0;
      r_refRank <= 1'b0;
    end else begin
      if (w_doOp) begin
        r_rank  <= i_reqRank;
        r_bank  <= i_reqBank;
        r_row   <= i_reqRow;
        r_col   <= i_reqCol;
        r_write <= i_reqWrite;
      end
      if (w_doReset) begin
        r_refRank <= i_refRankIn;
      end
    end
  end

endmodule

// File: tb/tb_ddr_cmd_seq.sv
// Self-checking bench for ddr_cmd_seq: table of request vectors plus
// hand-written refresh, deferral and reset sequences, with a command
// scoreboard checked every cycle.
module tb_ddr_cmd_seq;

  localparam int TRP  = 3;
  localparam int TRCD = 3;
  localparam int TRFC = 51;

  localparam logic [2:0] NOP    = 3'd0;
  localparam logic [2:0] PRE    = 3'd1;
  localparam logic [2:0] ACT    = 3'd2;
  localparam logic [2:0] RD     = 3'd3;
  localparam logic [2:0] WR     = 3'd4;
  localparam logic [2:0] PREALL = 3'd5;
  localparam logic [2:0] REF    = 3'd6;

  // kind: 0 = hit, 1 = miss, 2 = conflict
  typedef struct {
    logic [2:0]  numOps;
    logic        rank;
    logic [2:0]  bank;
    logic [13:0] row;
    logic [9:0]  col;
    logic        write;
    int          kind;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [2:0]  cmd;
    logic        rank;
    logic [2:0]  bank;
    logic [13:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqRank = 1'b0;
  logic [2:0]  reqBank = 3'd0;
  logic [13:0] reqRow = 14'd0;
  logic [9:0]  reqCol = 10'd0;
  logic        reqWrite = 1'b0;
  logic        doOp;
  logic [2:0]  numOps = 3'd0;
  logic        refReq = 1'b0;
  logic        refRankIn = 1'b0;
  logic        refAck;
  logic        doReset;
  logic        refRank;
  logic [2:0]  cmd;
  logic        cmdRank;
  logic [2:0]  cmdBank;
  logic [13:0] cmdAddr;

  int   cyc = 0;
  int   vecCount = 0;
  int   missCount = 0;
  exp_t expQ[$];
  exp_t monE;
  vec_t vecs[7];

  ddr_cmd_seq #(.TRP(TRP), .TRCD(TRCD), .TRFC(TRFC)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_reqValid  (reqValid),
    .o_reqReady  (reqReady),
    .i_reqRank   (reqRank),
    .i_reqBank   (reqBank),
    .i_reqRow    (reqRow),
    .i_reqCol    (reqCol),
    .i_reqWrite  (reqWrite),
    .o_doOp      (doOp),
    .i_numOps    (numOps),
    .i_refReq    (refReq),
    .i_refRankIn (refRankIn),
    .o_refAck    (refAck),
    .o_doReset   (doReset),
    .o_refRank   (refRank),
    .o_cmd       (cmd),
    .o_cmdRank   (cmdRank),
    .o_cmdBank   (cmdBank),
    .o_cmdAddr   (cmdAddr)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter, advanced on each active edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vecCount++;
    if (act !== req) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic pushExp(input int c, input logic [2:0] cm, input logic rk,
                         input logic [2:0] bk, input logic [13:0] ad);
    exp_t x;
    x.cyc  = c;
    x.cmd  = cm;
    x.rank = rk;
    x.bank = bk;
    x.addr = ad;
    expQ.push_back(x);
  endtask

  task automatic waitUntil(input int c);
    @(negedge clk);
    for (int k = 0; k < 1000 && cyc < c; k++) @(negedge clk);
    checkOutput("waitBound", 32'(cyc >= c), 32'd1);
  endtask

  // Every non-NOP command must match the head of the scoreboard, in cycle too
  always @(negedge clk) begin
    if (!rst && cmd != NOP) begin
      if (expQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL unexpectedCmd: got cmd=%0d at cycle %0d, required NOP", cmd, cyc);
      end else begin
        monE = expQ.pop_front();
        checkOutput("cmdCycle", 32'(cyc), 32'(monE.cyc));
        checkOutput("cmdFields", 32'({cmd, cmdRank, cmdBank, cmdAddr}),
                    32'({monE.cmd, monE.rank, monE.bank, monE.addr}));
      end
    end
  end

  task automatic applyStimulus(input vec_t v, input int idx);
    int a;
    int e;
    logic [2:0] rw;
    @(posedge clk); #1;
    reqValid = 1'b1;
    reqRank  = v.rank;
    reqBank  = v.bank;
    reqRow   = v.row;
    reqCol   = v.col;
    reqWrite = v.write;
    numOps   = v.numOps;
    @(negedge clk);
    for (int k = 0; k < 100 && !reqReady; k++) @(negedge clk);
    checkOutput($sformatf("v%0d.accept", idx), 32'(reqReady), 32'd1);
    checkOutput($sformatf("v%0d.doOp", idx), 32'(doOp), 32'd1);
    a  = cyc;
    rw = v.write ? WR : RD;
    case (v.kind)
      0: begin
        e = a + 2;
        pushExp(e, rw, v.rank, v.bank, {4'b0000, v.col});
      end
      1: begin
        pushExp(a + 2, ACT, v.rank, v.bank, v.row);
        e = a + 2 + TRCD;
        pushExp(e, rw, v.rank, v.bank, {4'b0000, v.col});
      end
      default: begin
        pushExp(a + 2, PRE, v.rank, v.bank, 14'd0);
        pushExp(a + 2 + TRP, ACT, v.rank, v.bank, v.row);
        e = a + 2 + TRP + TRCD;
        pushExp(e, rw, v.rank, v.bank, {4'b0000, v.col});
      end
    endcase
    @(posedge clk); #1;
    reqValid = 1'b0;
    waitUntil(e + 1);
    checkOutput($sformatf("v%0d.drain", idx), 32'(expQ.size()), 32'd0);
    checkOutput($sformatf("v%0d.readyAfter", idx), 32'(reqReady), 32'd1);
    expQ.delete();
  endtask

  // Refresh expected to start (doReset) in cycle s; returns the refAck cycle
  task automatic refreshCheck(input int s, input logic rk, output int ack);
    waitUntil(s);
    checkOutput("ref.doReset", 32'(doReset), 32'd1);
    checkOutput("ref.refRank", 32'(refRank), 32'(rk));
    checkOutput("ref.noDoOp", 32'(doOp), 32'd0);
    checkOutput("ref.readyLow", 32'(reqReady), 32'd0);
    pushExp(s + 1, PREALL, rk, 3'd0, 14'h0400);
    pushExp(s + 1 + TRP, REF, rk, 3'd0, 14'd0);
    ack = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (refAck) begin
        ack = cyc;
        break;
      end
    end
    checkOutput("ref.ackCycle", 32'(ack), 32'(s + 1 + TRP + TRFC));
    checkOutput("ref.drain", 32'(expQ.size()), 32'd0);
    checkOutput("ref.noRestart", 32'(doReset), 32'd0);
    expQ.delete();
    @(posedge clk); #1;
    refReq = 1'b0;
  endtask

  initial begin
    int a;
    int ack;

    vecs[0] = '{3'b001, 1'b0, 3'd2, 14'h0123, 10'h015, 1'b0, 0};
    vecs[1] = '{3'b010, 1'b1, 3'd5, 14'h1A2B, 10'h3FF, 1'b1, 1};
    vecs[2] = '{3'b100, 1'b0, 3'd7, 14'h3FFF, 10'h000, 1'b0, 2};
    vecs[3] = '{3'b000, 1'b1, 3'd1, 14'h2222, 10'h111, 1'b0, 2};
    vecs[4] = '{3'b111, 1'b0, 3'd3, 14'h0ABC, 10'h2CD, 1'b1, 2};
    vecs[5] = '{3'b001, 1'b1, 3'd0, 14'h1111, 10'h2AA, 1'b1, 0};
    vecs[6] = '{3'b011, 1'b0, 3'd6, 14'h0001, 10'h001, 1'b0, 2};

    // Reset state, with a request presented so ready/doOp gating is visible
    reqValid = 1'b1;
    #12;
    checkOutput("rst.cmd", 32'(cmd), 32'(NOP));
    checkOutput("rst.operands", 32'({cmdRank, cmdBank, cmdAddr}), 32'd0);
    checkOutput("rst.reqReady", 32'(reqReady), 32'd0);
    checkOutput("rst.doOp", 32'(doOp), 32'd0);
    checkOutput("rst.refAck", 32'(refAck), 32'd0);
    refReq = 1'b1;
    #1;
    checkOutput("rst.doReset", 32'(doReset), 32'd0);
    refReq   = 1'b0;
    reqValid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst.readyAfter", 32'(reqReady), 32'd1);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    // Refresh and request together: refresh wins, request taken right after
    @(posedge clk); #1;
    reqValid  = 1'b1;
    reqRank   = 1'b0;
    reqBank   = 3'd6;
    reqRow    = 14'h0555;
    reqCol    = 10'h0AA;
    reqWrite  = 1'b0;
    numOps    = 3'b001;
    refReq    = 1'b1;
    refRankIn = 1'b1;
    refreshCheck(cyc, 1'b1, ack);
    @(negedge clk);
    checkOutput("coll.acceptCycle", 32'(cyc), 32'(ack + 1));
    checkOutput("coll.doOp", 32'(doOp), 32'd1);
    a = cyc;
    pushExp(a + 2, RD, 1'b0, 3'd6, 14'h00AA);
    @(posedge clk); #1;
    reqValid = 1'b0;
    waitUntil(a + 3);
    checkOutput("coll.drain", 32'(expQ.size()), 32'd0);
    checkOutput("coll.readyAfter", 32'(reqReady), 32'd1);
    expQ.delete();

    // Refresh raised mid-request waits for the RD/WR
    @(posedge clk); #1;
    reqValid = 1'b1;
    reqRank  = 1'b1;
    reqBank  = 3'd4;
    reqRow   = 14'h2468;
    reqCol   = 10'h135;
    reqWrite = 1'b1;
    numOps   = 3'b100;
    @(negedge clk);
    checkOutput("defer.doOp", 32'(doOp), 32'd1);
    a = cyc;
    pushExp(a + 2, PRE, 1'b1, 3'd4, 14'd0);
    pushExp(a + 2 + TRP, ACT, 1'b1, 3'd4, 14'h2468);
    pushExp(a + 2 + TRP + TRCD, WR, 1'b1, 3'd4, 14'h0135);
    @(posedge clk); #1;
    reqValid  = 1'b0;
    refReq    = 1'b1;
    refRankIn = 1'b0;
    refreshCheck(a + 3 + TRP + TRCD, 1'b0, ack);

    // Reset during WAIT_RCD aborts the miss sequence before its WR
    @(posedge clk); #1;
    reqValid = 1'b1;
    reqRank  = 1'b1;
    reqBank  = 3'd4;
    reqRow   = 14'h0F0F;
    reqCol   = 10'h123;
    reqWrite = 1'b1;
    numOps   = 3'b010;
    @(negedge clk);
    checkOutput("rstMid.doOp", 32'(doOp), 32'd1);
    a = cyc;
    pushExp(a + 2, ACT, 1'b1, 3'd4, 14'h0F0F);
    @(posedge clk); #1;
    reqValid = 1'b0;
    waitUntil(a + 4);
    rst = 1'b1;
    #1;
    checkOutput("rstMid.cmd", 32'(cmd), 32'(NOP));
    checkOutput("rstMid.operands", 32'({cmdRank, cmdBank, cmdAddr}), 32'd0);
    checkOutput("rstMid.reqReady", 32'(reqReady), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstMid.readyAfter", 32'(reqReady), 32'd1);
    waitUntil(a + 16);
    checkOutput("rstMid.drain", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  // Guard against a hung sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, required to have finished", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
